rr_arbiter_n: RTL
=================

// Module: rr_arbiter_n
// PURPOSE
//   N-channel round-robin arbiter with grant hold: on trigger_i, picks one requester from
//   req_vec_i by rotating priority and holds the grant until the winner releases it.
//   Sits between the MCDF channel slaves and the formatter; generalises the fixed
//   4-way arbiter to N channels with packet-locked grants and optional weighting.
// PARAMETERS
//   N      4  number of requesting channels (2..16)
//   IDX_W  2  width of win_idx_o; must equal $clog2(N)
//   WGT_W  3  per-channel weight width (used only with RR_ARB_WEIGHT_EN)
// PORTS
//   clk_i        in   1        single clock, all logic on rising edge
//   rst_i        in   1        synchronous, active-high reset
//   req_vec_i    in   N        request vector, bit k = channel k
//   trigger_i    in   1        start one arbitration round
//   last_i       in   1        winner releases grant (end of packet)
//   weight_i     in   N*WGT_W  channel weights, ch k at [k*WGT_W +: WGT_W] (macro only)
//   win_vec_o    out  N        one-hot grant, registered
//   win_idx_o    out  IDX_W    binary index of granted channel
//   win_valid_o  out  1        a grant is held
// BEHAVIOUR
//   Reset (rst_i=1 at clk edge): win_vec_o=0, win_idx_o=0, win_valid_o=0, state IDLE,
//     priority pointer ptr = one-hot bit N-1, credit=0. Reset mid-grant aborts it.
//   Priority: ptr channel highest, then descending index, wrapping N-1 after 0.
//   FSM IDLE: trigger_i=1 and |req_vec_i -> GRANT; win_vec_o/idx/valid update at next
//     edge (1-cycle latency). trigger_i with req_vec_i=0 -> stay IDLE, outputs 0.
//   FSM GRANT: grant held steady; trigger_i ignored unless release occurs same cycle.
//     Release = last_i=1, or winner's req bit low. On release without trigger -> IDLE,
//     win_vec_o=0 and win_valid_o=0 next cycle. Release + trigger_i + any req ->
//     back-to-back: new winner next cycle, win_valid_o stays 1.
//   Pointer update at each grant to channel k: ptr <= one-hot bit (k-1) mod N
//     (k=0 wraps to N-1); the new arbitration uses the updated ptr.
//   win_vec_o is always zero or one-hot; win_idx_o matches it; idx=0 when valid=0.
//   Requests of non-winners are not latched; they must stay high to be considered.
// CONFIGURATION
//   RR_ARB_WEIGHT_EN defined: credit counter (WGT_W bits). Grant to a channel other than
//     the last winner loads credit=weight (0 treated as 1). If the last winner wins again
//     while credit>1, credit decrements and ptr does NOT move (stays on that channel);
//     ptr rotates as above when credit reaches 1. weight_i sampled at grant time.
//   Undefined: weight_i port absent, no counter; ptr rotates on every grant.
// STRUCTURE
//   Package rr_arb_pkg: state enum {ST_IDLE, ST_GRANT}, MAX_N=16, onehot2idx function.
//   Sub-module rr_arb_pick: combinational rotate-priority picker (req, ptr -> one-hot
//     winner, any flag); top holds FSM, pointer, credit and output registers.
// TESTING (N=4, WGT_W=3)
//   Reset, req=1100, trigger, last_i same cycle -> win_vec 1000, idx 3; repeat -> 0100;
//     repeat -> 1000 (wrap from ptr ch1 past ch0 to ch3).
//   req=0001 single trigger -> win 0001 one cycle later; ptr becomes ch3; next req=1001
//     trigger -> 1000.
//   GRANT ch3 held, trigger pulsed with last_i=0 -> win stays 1000; drop req[3] ->
//     win_vec 0000, valid 0 next cycle.
//   last_i+trigger with req=0110 while granted ch3 -> win 0100 next cycle, valid never 0.
//   rst_i asserted during GRANT -> next cycle all outputs 0; next trigger req=1111 -> 1000.
//   Macro on, weight ch3=2 others=1, req=1100 back-to-back -> ch3, ch3, ch2, ch3, ch3, ch2.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the N-channel round-robin arbiter.
// The optional weighting feature is selected by RR_ARB_WEIGHT_EN.
package rr_arb_pkg;

  localparam int MAX_N     = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Binary index of a one-hot vector; zero vector maps to 0.
  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_N-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (vec[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational rotate-priority picker: the ptr channel is highest priority,
// then descending index, wrapping from channel 0 to channel N-1.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] ptr_i,
  output logic [N-1:0] win_o,
  output logic         any_o
);

  logic [N-1:0] low_mask;
  logic [N-1:0] req_low;

  function automatic logic [N-1:0] msb_onehot(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Bits at or below the pointer; ptr at bit N-1 shifts out and yields all ones.
  assign low_mask = (ptr_i << 1) - {{(N-1){1'b0}}, 1'b1};
  assign req_low  = req_i & low_mask;
  assign any_o    = |req_i;

  always_comb begin
    win_o = '0;
    if (|req_low) win_o = msb_onehot(req_low);
    else          win_o = msb_onehot(req_i);
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-channel round-robin arbiter with packet-locked grants.
// Define RR_ARB_WEIGHT_EN to add per-channel weighted (credit) grants.
//
//   state    | meaning
//   ST_IDLE  | no grant held, waiting for trigger_i with a request present
//   ST_GRANT | win_vec_o holds one channel until last_i or its request drops
module rr_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2,
  parameter int WGT_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N-1:0]       req_vec_i,
  input  logic               trigger_i,
  input  logic               last_i,
`ifdef RR_ARB_WEIGHT_EN
  input  logic [N*WGT_W-1:0] weight_i,
`endif
  output logic [N-1:0]       win_vec_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               win_valid_o
);

  arb_state_e   state_q, state_d;
  logic [N-1:0] win_vec_q, win_vec_d;
  logic [N-1:0] ptr_q, ptr_d;
  logic [N-1:0] pick_vec;
  logic         pick_any;
  logic         released;
  logic         grant_go;

  rr_arb_pick #(.N(N)) u_pick (
    .req_i (req_vec_i),
    .ptr_i (ptr_q),
    .win_o (pick_vec),
    .any_o (pick_any)
  );

  function automatic logic [N-1:0] rot_down(input logic [N-1:0] v);
    return {v[0], v[N-1:1]};
  endfunction

`ifdef RR_ARB_WEIGHT_EN
  logic [WGT_W-1:0] credit_q, credit_d;
  logic [N-1:0]     last_win_q, last_win_d;
  logic [WGT_W-1:0] wgt_pick;

  always_comb begin
    wgt_pick = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_vec[i]) wgt_pick = weight_i[i*WGT_W +: WGT_W];
    end
  end
`endif

  always_comb begin
    released  = (state_q == ST_GRANT) && (last_i || !(|(req_vec_i & win_vec_q)));
    grant_go  = trigger_i && pick_any && ((state_q == ST_IDLE) || released);
    state_d   = state_q;
    win_vec_d = win_vec_q;
    ptr_d     = ptr_q;
`ifdef RR_ARB_WEIGHT_EN
    credit_d   = credit_q;
    last_win_d = last_win_q;
`endif
    if (grant_go) begin
      state_d   = ST_GRANT;
      win_vec_d = pick_vec;
`ifdef RR_ARB_WEIGHT_EN
      last_win_d = pick_vec;
      if ((pick_vec == last_win_q) && (credit_q > WGT_W'(1)))
        credit_d = credit_q - WGT_W'(1);
      else
        credit_d = (wgt_pick == '0) ? WGT_W'(1) : wgt_pick;
      // Pointer parks on the winner while it still has credit left.
      ptr_d = (credit_d > WGT_W'(1)) ? pick_vec : rot_down(pick_vec);
`else
      ptr_d = rot_down(pick_vec);
`endif
    end else if ((state_q == ST_IDLE) || released) begin
      state_d   = ST_IDLE;
      win_vec_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      win_vec_q <= '0;
      ptr_q     <= {1'b1, {(N-1){1'b0}}};
`ifdef RR_ARB_WEIGHT_EN
      credit_q   <= '0;
      last_win_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      win_vec_q <= win_vec_d;
      ptr_q     <= ptr_d;
`ifdef RR_ARB_WEIGHT_EN
      credit_q   <= credit_d;
      last_win_q <= last_win_d;
`endif
    end
  end

  assign win_vec_o   = win_vec_q;
  assign win_idx_o   = IDX_W'(onehot2idx(MAX_N'(win_vec_q)));
  assign win_valid_o = (state_q == ST_GRANT);

endmodule
